seq_pattern_tx: RTL and testbench

//   Serial bit-stream transmitter that feeds the 1011 sequence detector.
//   - Accepts parallel data words over a valid/ready handshake.
//   - Optionally prepends the sync pattern (default 1011).
//   - Shifts the frame out MSB-first, one bit per clock, then inserts an idle gap
//     of zeros so the downstream detector returns to its reset state.
//   - Sits between test/stimulus logic and the detector's single-bit `in` port.

---
 rtl/seq_pattern_pkg.sv | 19 +
 rtl/seq_piso_shreg.sv | 28 ++
 rtl/seq_pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the 1011 sync-pattern transmitter and its detector bench.
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        GAP      = 2'd3
    } tx_state_e;

    localparam logic [3:0]  SYNC_PATTERN = 4'b1011;
    localparam int unsigned SYNC_W       = 4;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register holding the payload word being serialised.
module seq_piso_shreg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_msb
);

    logic [DATA_W-1:0] r_shreg;

    // Load and shift together means the MSB is consumed in the load cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_shift ? (i_data << 1) : i_data;
        end else if (i_shift) begin
            r_shreg <= r_shreg << 1;
        end
    end

    assign o_msb = r_shreg[DATA_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial transmitter: optional sync pattern, MSB-first payload, then an idle gap of zeros.
// Registered state/count track the bit currently on tx_bit, so an accepted word shows its
// first bit in the very next cycle and in_ready returns one cycle after the final bit/gap.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      PAT_W      = SYNC_W,
    parameter logic [PAT_W-1:0] PATTERN    = PAT_W'(SYNC_PATTERN),
    parameter int unsigned      GAP_CYCLES = 2,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_preamble,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              tx_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int unsigned MAX_W = (DATA_W > PAT_W) ? DATA_W : PAT_W;
    localparam int unsigned BC_W  = cnt_width(MAX_W);
    localparam int unsigned GC_W  = cnt_width(GAP_CYCLES);

    localparam logic [BC_W-1:0] DATA_TOP   = BC_W'(DATA_W - 1);
    localparam logic [BC_W-1:0] PAT_TOP    = BC_W'(PAT_W - 1);
    localparam logic [GC_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GC_W'(GAP_CYCLES - 1) : '0;
    localparam logic            SINGLE_BIT = (DATA_W == 1);
    localparam logic            HAS_GAP    = (GAP_CYCLES > 0);

    tx_state_e          r_state;
    logic [BC_W-1:0]    r_bit_cnt;
    logic [GC_W-1:0]    r_gap_cnt;
    logic               r_tx_bit;
    logic               r_tx_valid;
    logic               r_tx_last;
    logic               r_busy;
    logic [CNT_W-1:0]   r_frame_count;

    logic               w_xfer;
    logic               w_sh_shift;
    logic               w_sh_msb;
    logic               w_last_next;
    logic [BC_W-1:0]    w_pat_idx;
    logic [PAT_W-1:0]   w_pat_shifted;
    logic               w_pat_bit;

    // Handshake decode, shift-register control and next-cycle tx_last.
    always_comb begin
        w_xfer      = in_valid && (r_state == IDLE);
        // Shift whenever the shreg MSB is moved onto tx_bit.
        w_sh_shift  = (w_xfer && !in_preamble)
                   || ((r_state == PREAMBLE) && (r_bit_cnt == '0))
                   || ((r_state == DATA) && (r_bit_cnt != '0));
        w_last_next = (w_xfer && !in_preamble && SINGLE_BIT)
                   || ((r_state == PREAMBLE) && (r_bit_cnt == '0) && SINGLE_BIT)
                   || ((r_state == DATA) && (r_bit_cnt == BC_W'(1)));
        w_pat_idx     = r_bit_cnt - 1'b1;
        w_pat_shifted = PATTERN >> w_pat_idx;
        w_pat_bit     = w_pat_shifted[0];
    end

    seq_piso_shreg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_xfer),
        .i_shift (w_sh_shift),
        .i_data  (in_data),
        .o_msb   (w_sh_msb)
    );

    // Frame FSM with registered serial outputs, bit/gap counters and frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_tx_bit      <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_tx_last <= w_last_next;
            if (w_last_next) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    r_tx_bit   <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    if (in_valid) begin
                        r_busy     <= 1'b1;
                        r_tx_valid <= 1'b1;
                        if (in_preamble) begin
                            r_state   <= PREAMBLE;
                            r_bit_cnt <= PAT_TOP;
                            r_tx_bit  <= PATTERN[PAT_W-1];
                        end else begin
                            r_state   <= DATA;
                            r_bit_cnt <= DATA_TOP;
                            r_tx_bit  <= in_data[DATA_W-1];
                        end
                    end
                end
                PREAMBLE: begin
                    if (r_bit_cnt == '0) begin
                        r_state   <= DATA;
                        r_bit_cnt <= DATA_TOP;
                        r_tx_bit  <= w_sh_msb;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        r_tx_bit  <= w_pat_bit;
                    end
                end
                DATA: begin
                    if (r_bit_cnt == '0) begin
                        r_tx_bit   <= 1'b0;
                        r_tx_valid <= 1'b0;
                        if (HAS_GAP) begin
                            r_state   <= GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        r_tx_bit  <= w_sh_msb;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign tx_bit      = r_tx_bit;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_last;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (gap 2 / 16-bit count, gap 0 / 4-bit count),
// a cycle timeline scoreboard, table-driven frame vectors and multi-cycle corner sequences.
module tb_seq_pattern_tx;
    import seq_pattern_pkg::*;

    localparam int unsigned GAP0 = 2;
    localparam int unsigned GAP1 = 0;
    localparam int unsigned MOD0 = 65536;
    localparam int unsigned MOD1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst, vld, pre, rdy, txb, txv, txl, bsy;
    logic [7:0]  dat0, dat1;
    logic [15:0] fc0;
    logic [3:0]  fc1;

    seq_pattern_tx #(
        .DATA_W (8), .PAT_W (SYNC_W), .PATTERN (SYNC_PATTERN), .GAP_CYCLES (GAP0), .CNT_W (16)
    ) u_dut0 (
        .clk (clk), .reset (rst[0]), .in_valid (vld[0]), .in_ready (rdy[0]), .in_data (dat0),
        .in_preamble (pre[0]), .tx_bit (txb[0]), .tx_valid (txv[0]), .tx_last (txl[0]),
        .busy (bsy[0]), .frame_count (fc0)
    );

    seq_pattern_tx #(
        .DATA_W (8), .PAT_W (SYNC_W), .PATTERN (SYNC_PATTERN), .GAP_CYCLES (GAP1), .CNT_W (4)
    ) u_dut1 (
        .clk (clk), .reset (rst[1]), .in_valid (vld[1]), .in_ready (rdy[1]), .in_data (dat1),
        .in_preamble (pre[1]), .tx_bit (txb[1]), .tx_valid (txv[1]), .tx_last (txl[1]),
        .busy (bsy[1]), .frame_count (fc1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Timeline model: each accepted word expands into one entry per output cycle.
    typedef struct packed {logic b; logic v; logic l;} ent_t;
    ent_t        q0[$];
    ent_t        q1[$];
    logic        m_ready[2];
    logic        m_init[2];
    logic        m_xfer[2];
    ent_t        m_exp[2];
    int unsigned m_cnt[2];
    int unsigned last_seen[2];

    typedef struct {
        logic [7:0]  data;
        logic        pre_b;
        int          len;
        logic [11:0] bits;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int d);
        logic [7:0]  w;
        logic [11:0] frame;
        logic [3:0]  pat;
        int          n;
        int unsigned gap;
        ent_t        e;
        pat = SYNC_PATTERN;
        gap = (d == 0) ? GAP0 : GAP1;
        if (rst[d]) begin
            if (d == 0) q0.delete(); else q1.delete();
            m_ready[d] = 1'b1;
            m_cnt[d]   = 0;
            m_init[d]  = 1'b1;
            m_xfer[d]  = 1'b0;
            m_exp[d]   = '0;
            return;
        end
        m_xfer[d] = vld[d] && m_ready[d];
        if (m_xfer[d]) begin
            w = (d == 0) ? dat0 : dat1;
            if (pre[d]) begin
                frame = {pat, w};
                n     = 12;
            end else begin
                frame = {4'b0000, w};
                n     = 8;
            end
            for (int i = n - 1; i >= 0; i--) begin
                e = '{b: frame[i], v: 1'b1, l: (i == 0)};
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            for (int i = 0; i < int'(gap); i++) begin
                if (d == 0) q0.push_back('0); else q1.push_back('0);
            end
        end
        if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            m_exp[d]   = e;
            m_ready[d] = 1'b0;
            if (e.l) m_cnt[d] = (m_cnt[d] + 1) % ((d == 0) ? MOD0 : MOD1);
        end else begin
            m_exp[d]   = '0;
            m_ready[d] = 1'b1;
        end
    endtask

    task automatic compare(input int d);
        logic [20:0] act;
        logic [20:0] exp;
        logic [15:0] fcv;
        if (!m_init[d]) return;
        fcv = (d == 0) ? fc0 : {12'b0, fc1};
        act = {rdy[d], txb[d], txv[d], txl[d], bsy[d], fcv};
        exp = {m_ready[d], m_exp[d].b, m_exp[d].v, m_exp[d].l, !m_ready[d], 16'(m_cnt[d])};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL sb_dut%0d at %0t: rdy/bit/vld/last/busy/fc got %b/%b/%b/%b/%b/%0d need %b/%b/%b/%b/%b/%0d",
                     d, $time, act[20], act[19], act[18], act[17], act[16], act[15:0],
                     exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
        if (txl[d] === 1'b1) last_seen[d]++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic wait_xfer(input int d);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            got = m_xfer[d];
        end
        check("xfer_timeout", 32'(got), 32'd1);
    endtask

    task automatic send(input int d, input logic [7:0] w, input logic p);
        if (d == 0) dat0 = w; else dat1 = w;
        pre[d] = p;
        vld[d] = 1'b1;
        wait_xfer(d);
        vld[d] = 1'b0;
    endtask

    task automatic capture(input int d, input int len, output logic [11:0] bits, output logic lst);
        bits = '0;
        lst  = 1'b0;
        for (int i = 0; i < len; i++) begin
            bits = {bits[10:0], txb[d]};
            if (i == len - 1) lst = txl[d];
            else tick();
        end
    endtask

    task automatic count_low(input int d, output int lows);
        lows = 0;
        while (rdy[d] === 1'b0 && lows < 60) begin
            lows++;
            tick();
        end
    endtask

    initial begin
        logic [11:0] bits;
        logic        lst;
        int          lows;
        int unsigned base;

        vt[0] = '{8'hA5, 1'b1, 12, 12'hBA5};
        vt[1] = '{8'h3C, 1'b0, 8,  12'h03C};
        vt[2] = '{8'h0B, 1'b1, 12, 12'hB0B};
        vt[3] = '{8'hFF, 1'b0, 8,  12'h0FF};
        vt[4] = '{8'h00, 1'b1, 12, 12'hB00};
        vt[5] = '{8'h01, 1'b0, 8,  12'h001};

        for (int d = 0; d < 2; d++) begin
            m_ready[d] = 1'b0; m_init[d] = 1'b0; m_xfer[d] = 1'b0;
            m_exp[d] = '0; m_cnt[d] = 0; last_seen[d] = 0;
        end
        rst = 2'b11; vld = '0; pre = '0; dat0 = '0; dat1 = '0;

        // Reset held three cycles, then released.
        repeat (3) tick();
        rst = 2'b00;
        check("rst_ready",  32'(rdy[0]), 32'd1);
        check("rst_valid",  32'(txv[0]), 32'd0);
        check("rst_bit",    32'(txb[0]), 32'd0);
        check("rst_fcount", 32'(fc0),    32'd0);
        check("rst_busy",   32'(bsy[1]), 32'd0);

        // Table-driven frames on the gap-2 instance.
        for (int i = 0; i < 6; i++) begin
            send(0, vt[i].data, vt[i].pre_b);
            capture(0, vt[i].len, bits, lst);
            check("vec_bits", 32'(bits), 32'(vt[i].bits));
            check("vec_last", 32'(lst), 32'd1);
            tick();
            tick();
            check("gap_not_ready", 32'(rdy[0]), 32'd0);
            check("gap_bit_zero",  32'(txb[0]), 32'd0);
            tick();
            check("ready_after_gap", 32'(rdy[0]), 32'd1);
            check("vec_fcount", 32'(fc0), 32'(i + 1));
        end

        // Back-to-back words with in_valid held high on the gap-0 instance.
        dat1 = 8'hFF; pre[1] = 1'b0; vld[1] = 1'b1;
        wait_xfer(1);
        dat1 = 8'h0B;
        count_low(1, lows);
        check("b2b_low_first", 32'(lows), 32'd8);
        wait_xfer(1);
        vld[1] = 1'b0;
        count_low(1, lows);
        check("b2b_low_second", 32'(lows), 32'd8);
        check("b2b_fcount", 32'(fc1), 32'd2);

        // Reset on the third payload bit aborts the frame.
        send(0, 8'hA5, 1'b0);
        tick();
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("abort_valid",  32'(txv[0]), 32'd0);
        check("abort_busy",   32'(bsy[0]), 32'd0);
        check("abort_fcount", 32'(fc0),    32'd0);
        send(0, 8'h3C, 1'b0);
        capture(0, 8, bits, lst);
        check("after_abort_bits", 32'(bits), 32'h03C);
        check("after_abort_last", 32'(lst), 32'd1);

        // Frame counter wrap on the 4-bit instance.
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        base = last_seen[1];
        for (int i = 1; i <= 17; i++) begin
            send(1, 8'($urandom), 1'($urandom));
            count_low(1, lows);
            check("wrap_fcount", 32'(fc1), 32'(i % 16));
        end
        check("wrap_last_pulses", 32'(last_seen[1] - base), 32'd17);

        // Randomised traffic with occasional resets, checked by the timeline model.
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                vld[d] = ($urandom_range(0, 2) != 0);
                pre[d] = 1'($urandom);
                rst[d] = ($urandom_range(0, 199) == 0);
            end
            dat0 = 8'($urandom);
            dat1 = 8'($urandom);
            tick();
        end
        rst = '0; vld = '0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
